// File: rtl/mips_hazard_pkg.sv
// Shared definitions for the MIPS hazard/pipeline-control unit:
// forwarding mux codes, flush FSM states and the forwarding priority helper.
package mips_hazard_pkg;

  typedef enum logic [1:0] {
    FWD_REG     = 2'd0,
    FWD_ALU_MEM = 2'd1,
    FWD_LMD_MEM = 2'd2,
    FWD_WB      = 2'd3
  } fwd_sel_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } flush_state_e;

  // MEM always beats WB. When loads are stalled until WB, the LMD path is
  // never selected, so a MEM-stage hit is always reported as the ALU result.
  function automatic fwd_sel_e fwd_code(input logic mem_hit,
                                        input logic mem_load,
                                        input logic wb_hit,
                                        input logic no_lmd);
    fwd_sel_e code;
    if (mem_hit) begin
      if (mem_load && !no_lmd) begin
        code = FWD_LMD_MEM;
      end else begin
        code = FWD_ALU_MEM;
      end
    end else if (wb_hit) begin
      code = FWD_WB;
    end else begin
      code = FWD_REG;
    end
    return code;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_fwd_select.sv
// One EXE-operand forwarding comparator: checks a single source address
// against the MEM and WB destinations and returns the bypass mux code.
module fwd_select
  import mips_hazard_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter bit NO_LMD = 1'b0
) (
  input  logic [ADDR_W-1:0] src_addr,
  input  logic              mem_wb_wen,
  input  logic [ADDR_W-1:0] mem_regw_addr,
  input  logic              mem_mem_ren,
  input  logic              wb_wb_wen,
  input  logic [ADDR_W-1:0] wb_regw_addr,
  output logic [1:0]        sel
);

  logic mem_hit_s;
  logic wb_hit_s;

  // Register $0 is never a valid forwarding source
  always_comb begin
    mem_hit_s = mem_wb_wen && (mem_regw_addr != {ADDR_W{1'b0}}) && (mem_regw_addr == src_addr);
    wb_hit_s  = wb_wb_wen && (wb_regw_addr != {ADDR_W{1'b0}}) && (wb_regw_addr == src_addr);
    sel       = fwd_code(mem_hit_s, mem_mem_ren, wb_hit_s, NO_LMD);
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and pipeline-control unit for the 5-stage MIPS core: operand
// forwarding, load-use stall, branch flush sequencing, memory-wait freeze,
// debug single-step and saturating event counters.
module pipeline_hazard_ctrl
  import mips_hazard_pkg::*;
#(
  parameter int ADDR_W         = 5,
  parameter int NUM_SRC        = 2,
  parameter int BRANCH_DELAY   = 3,
  parameter int LOAD_USE_STALL = 0,
  parameter int CNT_W          = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      debug_en,
  input  logic                      debug_step,
  input  logic                      id_rs_used,
  input  logic                      id_rt_used,
  input  logic [ADDR_W-1:0]         id_addr_rs,
  input  logic [ADDR_W-1:0]         id_addr_rt,
  input  logic                      id_is_branch,
  input  logic [NUM_SRC*ADDR_W-1:0] exe_src_addr,
  input  logic                      exe_wb_wen,
  input  logic                      mem_wb_wen,
  input  logic                      wb_wb_wen,
  input  logic [ADDR_W-1:0]         exe_regw_addr,
  input  logic [ADDR_W-1:0]         mem_regw_addr,
  input  logic [ADDR_W-1:0]         wb_regw_addr,
  input  logic                      exe_mem_ren,
  input  logic                      mem_mem_ren,
  input  logic                      mem_mem_wen,
  input  logic                      dmem_ready,
  output logic [NUM_SRC*2-1:0]      fwd_sel,
  output logic                      if_en,
  output logic                      id_en,
  output logic                      exe_en,
  output logic                      mem_en,
  output logic                      wb_en,
  output logic                      if_rst,
  output logic                      id_rst,
  output logic                      exe_rst,
  output logic                      mem_rst,
  output logic                      wb_rst,
  output logic [CNT_W-1:0]          stall_count,
  output logic [CNT_W-1:0]          flush_count,
  output logic [CNT_W-1:0]          memwait_count
);

  localparam int             CW         = $clog2(BRANCH_DELAY + 1);
  localparam logic [CW-1:0]  CNT_ONE    = CW'(1);
  localparam logic [CW-1:0]  CNT_RELOAD = CW'(BRANCH_DELAY - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam bit             LUS_MODE   = (LOAD_USE_STALL != 0);

  // A used, nonzero source matching the destination of a register-writing load
  function automatic logic src_match(input logic              used,
                                     input logic [ADDR_W-1:0] src,
                                     input logic              is_load,
                                     input logic [ADDR_W-1:0] dst);
    return used && (src != {ADDR_W{1'b0}}) && is_load && (src == dst);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic ev);
    logic [CNT_W-1:0] r;
    if (ev && (v != CNT_MAX)) begin
      r = v + CNT_W'(1);
    end else begin
      r = v;
    end
    return r;
  endfunction

  logic                 rst_hold_q, rst_hold_d;
  logic                 step_prev_q, step_prev_d;
  flush_state_e         state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [CNT_W-1:0]     stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]     flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0]     mw_cnt_q, mw_cnt_d;

  logic [NUM_SRC*2-1:0] fwd_raw_s;
  logic                 hold_s, memwait_s, load_use_s, flush_req_s;
  logic                 act_freeze_s, act_memwait_s, act_stall_s, act_flush_s;
  logic [4:0]           en_s, rst_s;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_fwd
    fwd_select #(
      .ADDR_W (ADDR_W),
      .NO_LMD (LUS_MODE)
    ) u_fwd (
      .src_addr      (exe_src_addr[i*ADDR_W +: ADDR_W]),
      .mem_wb_wen    (mem_wb_wen),
      .mem_regw_addr (mem_regw_addr),
      .mem_mem_ren   (mem_mem_ren),
      .wb_wb_wen     (wb_wb_wen),
      .wb_regw_addr  (wb_regw_addr),
      .sel           (fwd_raw_s[i*2 +: 2])
    );
  end

  // Detect candidate actions and pick the single highest-priority winner
  always_comb begin
    hold_s      = debug_en && !(debug_step && !step_prev_q);
    memwait_s   = (mem_mem_ren || mem_mem_wen) && !dmem_ready;
    load_use_s  = src_match(id_rs_used, id_addr_rs, exe_mem_ren && exe_wb_wen, exe_regw_addr)
               || src_match(id_rt_used, id_addr_rt, exe_mem_ren && exe_wb_wen, exe_regw_addr)
               || (LUS_MODE && src_match(id_rs_used, id_addr_rs, mem_mem_ren && mem_wb_wen, mem_regw_addr))
               || (LUS_MODE && src_match(id_rt_used, id_addr_rt, mem_mem_ren && mem_wb_wen, mem_regw_addr));
    flush_req_s = (state_q == ST_FLUSH) || id_is_branch;

    act_freeze_s  = 1'b0;
    act_memwait_s = 1'b0;
    act_stall_s   = 1'b0;
    act_flush_s   = 1'b0;
    if (rst_hold_q) begin
      act_freeze_s = 1'b0;
    end else if (hold_s) begin
      act_freeze_s = 1'b1;
    end else if (memwait_s) begin
      act_freeze_s  = 1'b1;
      act_memwait_s = 1'b1;
    end else if (load_use_s) begin
      act_stall_s = 1'b1;
    end else if (flush_req_s) begin
      act_flush_s = 1'b1;
    end else begin
      act_flush_s = 1'b0;
    end
  end

  // Stage enables/resets and forwarding; held at reset values until the first edge after release
  always_comb begin
    en_s    = 5'b11111;
    rst_s   = 5'b00000;
    fwd_sel = {(NUM_SRC*2){1'b0}};
    if (rst_hold_q) begin
      rst_s = 5'b11111;
    end else begin
      fwd_sel = fwd_raw_s;
      if (act_freeze_s) begin
        en_s = 5'b00000;
      end else if (act_stall_s) begin
        en_s  = 5'b00111;
        rst_s = 5'b00100;
      end else if (act_flush_s) begin
        rst_s = 5'b01000;
      end else begin
        rst_s = 5'b00000;
      end
    end
  end

  assign {if_en, id_en, exe_en, mem_en, wb_en}      = en_s;
  assign {if_rst, id_rst, exe_rst, mem_rst, wb_rst} = rst_s;

  // Flush sequencer: only moves in cycles where the flush action wins
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (act_flush_s) begin
      case (state_q)
        ST_IDLE: begin
          if (BRANCH_DELAY > 1) begin
            state_d = ST_FLUSH;
            cnt_d   = CNT_RELOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_FLUSH: begin
          if (cnt_q <= CNT_ONE) begin
            state_d = ST_IDLE;
            cnt_d   = {CW{1'b0}};
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = {CW{1'b0}};
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Counter increments and step-edge history
  always_comb begin
    stall_cnt_d = sat_inc(stall_cnt_q, act_stall_s);
    flush_cnt_d = sat_inc(flush_cnt_q, act_flush_s);
    mw_cnt_d    = sat_inc(mw_cnt_q, act_memwait_s);
    step_prev_d = debug_step;
    rst_hold_d  = 1'b0;
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rst_hold_q  <= 1'b1;
      step_prev_q <= 1'b0;
      state_q     <= ST_IDLE;
      cnt_q       <= {CW{1'b0}};
      stall_cnt_q <= {CNT_W{1'b0}};
      flush_cnt_q <= {CNT_W{1'b0}};
      mw_cnt_q    <= {CNT_W{1'b0}};
    end else begin
      rst_hold_q  <= rst_hold_d;
      step_prev_q <= step_prev_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      mw_cnt_q    <= mw_cnt_d;
    end
  end

  assign stall_count   = stall_cnt_q;
  assign flush_count   = flush_cnt_q;
  assign memwait_count = mw_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: two instances (forward-from-MEM mode with
// 3-cycle flush, stall-until-WB mode with 2-cycle flush and 4-bit counters)
// share the same stimulus and are compared every cycle against a rule model.
`timescale 1ns/100ps
module tb_pipeline_hazard_ctrl;
  localparam int AW   = 5;
  localparam int BD0  = 3;
  localparam int BD1  = 2;
  localparam int MAX0 = 65535;
  localparam int MAX1 = 15;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic debug_en, debug_step, id_rs_used, id_rt_used, id_is_branch;
  logic [AW-1:0] id_addr_rs, id_addr_rt, exe_regw_addr, mem_regw_addr, wb_regw_addr;
  logic [2*AW-1:0] exe_src_addr;
  logic exe_wb_wen, mem_wb_wen, wb_wb_wen, exe_mem_ren, mem_mem_ren, mem_mem_wen, dmem_ready;

  logic [4:0]  en0, rs0, en1, rs1;
  logic [3:0]  fwd0, fwd1;
  logic [15:0] st0, fl0, mw0;
  logic [3:0]  st1, fl1, mw1;

  int vectors = 0;
  int miscompares = 0;

  pipeline_hazard_ctrl #(.ADDR_W(AW), .NUM_SRC(2), .BRANCH_DELAY(BD0), .LOAD_USE_STALL(0), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .debug_en(debug_en), .debug_step(debug_step),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_addr_rs(id_addr_rs), .id_addr_rt(id_addr_rt),
    .id_is_branch(id_is_branch), .exe_src_addr(exe_src_addr),
    .exe_wb_wen(exe_wb_wen), .mem_wb_wen(mem_wb_wen), .wb_wb_wen(wb_wb_wen),
    .exe_regw_addr(exe_regw_addr), .mem_regw_addr(mem_regw_addr), .wb_regw_addr(wb_regw_addr),
    .exe_mem_ren(exe_mem_ren), .mem_mem_ren(mem_mem_ren), .mem_mem_wen(mem_mem_wen), .dmem_ready(dmem_ready),
    .fwd_sel(fwd0),
    .if_en(en0[4]), .id_en(en0[3]), .exe_en(en0[2]), .mem_en(en0[1]), .wb_en(en0[0]),
    .if_rst(rs0[4]), .id_rst(rs0[3]), .exe_rst(rs0[2]), .mem_rst(rs0[1]), .wb_rst(rs0[0]),
    .stall_count(st0), .flush_count(fl0), .memwait_count(mw0));

  pipeline_hazard_ctrl #(.ADDR_W(AW), .NUM_SRC(2), .BRANCH_DELAY(BD1), .LOAD_USE_STALL(1), .CNT_W(4)) dut1 (
    .clk(clk), .rst(rst), .debug_en(debug_en), .debug_step(debug_step),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_addr_rs(id_addr_rs), .id_addr_rt(id_addr_rt),
    .id_is_branch(id_is_branch), .exe_src_addr(exe_src_addr),
    .exe_wb_wen(exe_wb_wen), .mem_wb_wen(mem_wb_wen), .wb_wb_wen(wb_wb_wen),
    .exe_regw_addr(exe_regw_addr), .mem_regw_addr(mem_regw_addr), .wb_regw_addr(wb_regw_addr),
    .exe_mem_ren(exe_mem_ren), .mem_mem_ren(mem_mem_ren), .mem_mem_wen(mem_mem_wen), .dmem_ready(dmem_ready),
    .fwd_sel(fwd1),
    .if_en(en1[4]), .id_en(en1[3]), .exe_en(en1[2]), .mem_en(en1[1]), .wb_en(en1[0]),
    .if_rst(rs1[4]), .id_rst(rs1[3]), .exe_rst(rs1[2]), .mem_rst(rs1[1]), .wb_rst(rs1[0]),
    .stall_count(st1), .flush_count(fl1), .memwait_count(mw1));

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [4:0] en;
    logic [4:0] rs;
    logic [3:0] fwd;
    logic       lu;
    logic       mw;
    logic       fl;
  } exp_t;

  bit m_hold;              // reset values still showing
  bit m_prev;              // previous debug_step
  int m_left [2];          // flush cycles still owed after the current one
  int m_st [2];
  int m_fl [2];
  int m_mw [2];

  function automatic logic [1:0] m_fwd(input logic [AW-1:0] a, input bit mode1);
    if (mem_wb_wen && mem_regw_addr != 0 && mem_regw_addr == a) return (mem_mem_ren && !mode1) ? 2'd2 : 2'd1;
    if (wb_wb_wen && wb_regw_addr != 0 && wb_regw_addr == a) return 2'd3;
    return 2'd0;
  endfunction

  function automatic bit m_lu(input bit mode1);
    logic [AW-1:0] srcs [2];
    bit used [2];
    srcs[0] = id_addr_rs; srcs[1] = id_addr_rt;
    used[0] = id_rs_used; used[1] = id_rt_used;
    for (int s = 0; s < 2; s++) begin
      if (used[s] && srcs[s] != 0) begin
        if (exe_mem_ren && exe_wb_wen && exe_regw_addr == srcs[s]) return 1'b1;
        if (mode1 && mem_mem_ren && mem_wb_wen && mem_regw_addr == srcs[s]) return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  function automatic exp_t model_out(input int k);
    exp_t e;
    bit hold, mw, mode1;
    mode1 = (k == 1);
    e.en = 5'b11111; e.rs = 5'b00000; e.lu = 1'b0; e.mw = 1'b0; e.fl = 1'b0;
    e.fwd = {m_fwd(exe_src_addr[2*AW-1:AW], mode1), m_fwd(exe_src_addr[AW-1:0], mode1)};
    if (m_hold) begin
      e.rs = 5'b11111; e.fwd = 4'd0;
      return e;
    end
    hold = debug_en && !(debug_step && !m_prev);
    mw   = (mem_mem_ren || mem_mem_wen) && !dmem_ready;
    if (hold) e.en = 5'b00000;
    else if (mw) begin e.en = 5'b00000; e.mw = 1'b1; end
    else if (m_lu(mode1)) begin e.en = 5'b00111; e.rs = 5'b00100; e.lu = 1'b1; end
    else if (m_left[k] > 0 || id_is_branch) begin e.rs = 5'b01000; e.fl = 1'b1; end
    return e;
  endfunction

  function automatic int sat(input int v, input bit ev, input int mx);
    return (ev && v < mx) ? v + 1 : v;
  endfunction

  function automatic int next_left(input int left, input bit fl, input int bd);
    if (!fl) return left;
    return (left == 0) ? bd - 1 : left - 1;
  endfunction

  exp_t u0, u1;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_hold <= 1'b1; m_prev <= 1'b0;
      m_left[0] <= 0; m_left[1] <= 0;
      m_st[0] <= 0; m_st[1] <= 0; m_fl[0] <= 0; m_fl[1] <= 0; m_mw[0] <= 0; m_mw[1] <= 0;
    end else begin
      u0 = model_out(0);
      u1 = model_out(1);
      m_hold <= 1'b0;
      m_prev <= debug_step;
      m_left[0] <= next_left(m_left[0], u0.fl, BD0);
      m_left[1] <= next_left(m_left[1], u1.fl, BD1);
      m_st[0] <= sat(m_st[0], u0.lu, MAX0); m_st[1] <= sat(m_st[1], u1.lu, MAX1);
      m_fl[0] <= sat(m_fl[0], u0.fl, MAX0); m_fl[1] <= sat(m_fl[1], u1.fl, MAX1);
      m_mw[0] <= sat(m_mw[0], u0.mw, MAX0); m_mw[1] <= sat(m_mw[1], u1.mw, MAX1);
    end
  end

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model, mid low phase
  exp_t c0, c1;
  always @(negedge clk) begin
    c0 = model_out(0);
    c1 = model_out(1);
    cmp("en0", {27'd0, en0}, {27'd0, c0.en});
    cmp("rst0", {27'd0, rs0}, {27'd0, c0.rs});
    cmp("fwd0", {28'd0, fwd0}, {28'd0, c0.fwd});
    cmp("stall_cnt0", {16'd0, st0}, m_st[0]);
    cmp("flush_cnt0", {16'd0, fl0}, m_fl[0]);
    cmp("memwait_cnt0", {16'd0, mw0}, m_mw[0]);
    cmp("en1", {27'd0, en1}, {27'd0, c1.en});
    cmp("rst1", {27'd0, rs1}, {27'd0, c1.rs});
    cmp("fwd1", {28'd0, fwd1}, {28'd0, c1.fwd});
    cmp("stall_cnt1", {28'd0, st1}, m_st[1]);
    cmp("flush_cnt1", {28'd0, fl1}, m_fl[1]);
    cmp("memwait_cnt1", {28'd0, mw1}, m_mw[1]);
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    debug_en = 1'b0; debug_step = 1'b0; id_rs_used = 1'b0; id_rt_used = 1'b0; id_is_branch = 1'b0;
    id_addr_rs = '0; id_addr_rt = '0; exe_regw_addr = '0; mem_regw_addr = '0; wb_regw_addr = '0;
    exe_src_addr = '0; exe_wb_wen = 1'b0; mem_wb_wen = 1'b0; wb_wb_wen = 1'b0;
    exe_mem_ren = 1'b0; mem_mem_ren = 1'b0; mem_mem_wen = 1'b0; dmem_ready = 1'b1;
  endtask

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    nxt();
    rst = 1'b0;
    nxt();
  endtask

  logic [7:0] p0, p1;
  int n0, n1;
  bit steps [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

  initial begin
    idle();
    rst = 1'b1;
    #1;
    settle();
    cmp("reset_rst0", {27'd0, rs0}, 32'h1f);
    cmp("reset_en0", {27'd0, en0}, 32'h1f);
    cmp("reset_cnt0", {16'd0, st0}, 32'd0);
    nxt(); nxt();
    rst = 1'b0;
    nxt();

    // Forwarding priority and $0 exclusion
    mem_wb_wen = 1'b1; mem_regw_addr = 5'd1; wb_wb_wen = 1'b1; wb_regw_addr = 5'd1;
    exe_src_addr = {5'd5, 5'd1};
    settle();
    cmp("t1_mem_beats_wb", {28'd0, fwd0}, 32'h1);
    nxt(); mem_mem_ren = 1'b1; settle();
    cmp("t1_lmd_mode0", {28'd0, fwd0}, 32'h2);
    cmp("t1_no_lmd_mode1", {28'd0, fwd1}, 32'h1);
    nxt(); mem_mem_ren = 1'b0; mem_regw_addr = 5'd0; wb_regw_addr = 5'd0; settle();
    cmp("t1_dest_zero", {28'd0, fwd0}, 32'h0);
    nxt(); wb_regw_addr = 5'd1; settle();
    cmp("t1_wb_only", {28'd0, fwd0}, 32'h3);

    // Load-use in both modes
    do_reset();
    exe_mem_ren = 1'b1; exe_wb_wen = 1'b1; exe_regw_addr = 5'd2; id_rs_used = 1'b1; id_addr_rs = 5'd2;
    settle();
    cmp("t2_stall_en0", {27'd0, en0}, 32'h07);
    cmp("t2_stall_rst0", {27'd0, rs0}, 32'h04);
    cmp("t2_stall_en1", {27'd0, en1}, 32'h07);
    nxt();
    exe_mem_ren = 1'b0; exe_wb_wen = 1'b0; exe_regw_addr = 5'd0;
    mem_mem_ren = 1'b1; mem_wb_wen = 1'b1; mem_regw_addr = 5'd2; exe_src_addr = {5'd0, 5'd2};
    settle();
    cmp("t2_mode0_released", {27'd0, en0}, 32'h1f);
    cmp("t2_mode0_lmd", {28'd0, fwd0}, 32'h2);
    cmp("t2_mode0_stall_cnt", {16'd0, st0}, 32'd1);
    cmp("t2_mode1_second_stall", {27'd0, en1}, 32'h07);
    nxt();
    mem_mem_ren = 1'b0; mem_wb_wen = 1'b0; mem_regw_addr = 5'd0;
    wb_wb_wen = 1'b1; wb_regw_addr = 5'd2; id_rs_used = 1'b0;
    settle();
    cmp("t2_mode1_wb_fwd", {28'd0, fwd1}, 32'h3);
    cmp("t2_mode1_released", {27'd0, en1}, 32'h1f);
    cmp("t2_mode1_stall_cnt", {28'd0, st1}, 32'd2);

    // Branch flush length
    do_reset();
    id_is_branch = 1'b1; p0 = '0; p1 = '0;
    for (int i = 0; i < 6; i++) begin
      settle(); p0[i] = rs0[3]; p1[i] = rs1[3];
      nxt(); id_is_branch = 1'b0;
    end
    settle();
    cmp("t3_flush_pattern0", {24'd0, p0}, 32'h07);
    cmp("t3_flush_pattern1", {24'd0, p1}, 32'h03);
    cmp("t3_flush_cnt0", {16'd0, fl0}, 32'd3);

    // Branch flush frozen by memory wait
    do_reset();
    p0 = '0; p1 = '0;
    for (int i = 0; i < 8; i++) begin
      id_is_branch = (i == 0);
      if (i == 1 || i == 2) begin mem_mem_ren = 1'b1; dmem_ready = 1'b0; end
      else begin mem_mem_ren = 1'b0; dmem_ready = 1'b1; end
      settle(); p0[i] = rs0[3]; p1[i] = rs1[3];
      nxt();
    end
    idle(); settle();
    cmp("t3_mw_pattern0", {24'd0, p0}, 32'h19);
    cmp("t3_mw_pattern1", {24'd0, p1}, 32'h09);
    cmp("t3_mw_cnt0", {16'd0, mw0}, 32'd2);
    cmp("t3_mw_flush_cnt0", {16'd0, fl0}, 32'd3);

    // Jump stalled by load-use, flush starts after the stall
    do_reset();
    id_is_branch = 1'b1; id_rs_used = 1'b1; id_addr_rs = 5'd3;
    exe_mem_ren = 1'b1; exe_wb_wen = 1'b1; exe_regw_addr = 5'd3;
    settle();
    cmp("t4_stall_first", {27'd0, rs0}, 32'h04);
    nxt();
    exe_mem_ren = 1'b0; exe_wb_wen = 1'b0; exe_regw_addr = 5'd0;
    mem_mem_ren = 1'b1; mem_wb_wen = 1'b1; mem_regw_addr = 5'd3;
    settle();
    cmp("t4_flush_after", {27'd0, rs0}, 32'h08);
    cmp("t4_en_after", {27'd0, en0}, 32'h1f);
    nxt(); idle(); nxt(); nxt(); nxt();

    // Debug single step
    do_reset();
    debug_en = 1'b1; n0 = 0; n1 = 0; p0 = '0;
    for (int i = 0; i < 8; i++) begin
      debug_step = steps[i];
      settle();
      p0[i] = en0[4];
      n0 += en0[4] + en0[3] + en0[2] + en0[1] + en0[0];
      n1 += en1[4] + en1[3] + en1[2] + en1[1] + en1[0];
      nxt();
    end
    idle();
    cmp("t5_step_pattern", {24'd0, p0}, 32'h24);
    cmp("t5_enable_sum0", n0, 32'd10);
    cmp("t5_enable_sum1", n1, 32'd10);

    // Reset in the middle of a flush
    do_reset();
    id_is_branch = 1'b1;
    settle(); nxt();
    id_is_branch = 1'b0;
    settle();
    cmp("t6_in_flush", {27'd0, rs0}, 32'h08);
    rst = 1'b1;
    #1;
    cmp("t6_async_rst", {27'd0, rs0}, 32'h1f);
    cmp("t6_async_en", {27'd0, en0}, 32'h1f);
    cmp("t6_async_cnt", {16'd0, fl0}, 32'd0);
    nxt();
    rst = 1'b0;
    settle();
    cmp("t6_release_pending", {27'd0, rs0}, 32'h1f);
    nxt(); settle();
    cmp("t6_no_residual", {27'd0, rs0}, 32'h00);
    nxt(); settle();
    cmp("t6_no_residual2", {27'd0, rs0}, 32'h00);
    nxt();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 399) == 0) rst = 1'b1;
      debug_en      = ($urandom_range(0, 7) == 0);
      debug_step    = 1'($urandom_range(0, 1));
      id_rs_used    = 1'($urandom_range(0, 1));
      id_rt_used    = 1'($urandom_range(0, 1));
      id_addr_rs    = 5'($urandom_range(0, 3));
      id_addr_rt    = 5'($urandom_range(0, 3));
      id_is_branch  = ($urandom_range(0, 5) == 0);
      exe_src_addr  = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      exe_wb_wen    = 1'($urandom_range(0, 1));
      mem_wb_wen    = 1'($urandom_range(0, 1));
      wb_wb_wen     = 1'($urandom_range(0, 1));
      exe_regw_addr = 5'($urandom_range(0, 3));
      mem_regw_addr = 5'($urandom_range(0, 3));
      wb_regw_addr  = 5'($urandom_range(0, 3));
      exe_mem_ren   = ($urandom_range(0, 2) == 0);
      mem_mem_ren   = ($urandom_range(0, 2) == 0);
      mem_mem_wen   = ($urandom_range(0, 4) == 0);
      dmem_ready    = ($urandom_range(0, 5) != 0);
      nxt();
    end
    rst = 1'b0;
    idle();
    nxt(); nxt();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Parametrised hazard and pipeline-control unit for the 5-stage MIPS core. It combines four functions:
- EXE-stage operand forwarding for NUM_SRC source ports.
- Load-use stall detection in two modes.
- Branch/jump flush sequencing through a counter FSM.
- Data-memory wait freeze and debug single-step.
It drives the per-stage en/rst signals and saturating performance counters. It sits beside the decoder and replaces the hazard logic currently embedded in controller.

Parameters:
ADDR_W, 5, register address width
NUM_SRC, 2, EXE source operands needing forwarding (port 0 = rs, 1 = rt)
BRANCH_DELAY, 3, cycles of IF/ID flush per taken control transfer (>=1)
LOAD_USE_STALL, 0, 0: forward load data from MEM (LMD); 1: stall until load reaches WB
CNT_W, 16, performance counter width

Ports:
clk  in  1  main clock
rst  in  1  reset, asynchronous, active-high
debug_en  in  1  hold pipeline except on step
debug_step  in  1  step request, rising-edge sensitive
id_rs_used, id_rt_used  in  1 each  ID instruction reads rs/rt
id_addr_rs, id_addr_rt  in  ADDR_W each  ID source addresses
id_is_branch  in  1  ID holds jump/branch (pc_src != next)
exe_src_addr  in  NUM_SRC*ADDR_W  EXE source addresses, port i at [i*ADDR_W +: ADDR_W]
exe_wb_wen, mem_wb_wen, wb_wb_wen  in  1 each  stage register-write enable
exe_regw_addr, mem_regw_addr, wb_regw_addr  in  ADDR_W each  stage destination
exe_mem_ren, mem_mem_ren  in  1 each  stage instruction is a load
mem_mem_wen  in  1  MEM instruction is a store
dmem_ready  in  1  data memory completes access this cycle
fwd_sel  out  NUM_SRC*2  per port: 0 reg, 1 ALU@MEM, 2 LMD@MEM, 3 WB
if_en, id_en, exe_en, mem_en, wb_en  out  1  stage enables
if_rst, id_rst, exe_rst, mem_rst, wb_rst  out  1  stage resets
stall_count, flush_count, memwait_count  out  CNT_W each  saturating event counters

Behaviour:
- Reset (async): all *_rst=1, all *_en=1, fwd_sel=0, counters=0, FSM=IDLE, step_prev=0. Release takes effect on the next clk edge.
- Forwarding (combinational, every port i):
  - MEM hit: mem_wb_wen and mem_regw_addr != 0 and equal to src_i. Code 2 if mem_mem_ren, else 1.
  - Otherwise WB hit (same test on WB) gives code 3; otherwise 0. MEM always beats WB.
  - LOAD_USE_STALL=1 never produces code 2.
- Load-use hazard: an ID-used source (nonzero address) matches a load destination.
  - Mode 0: match against the load in EXE only.
  - Mode 1: match against the load in EXE or MEM.
  - On hazard: if_en=id_en=0, exe_rst=1.
- Memwait: (mem_mem_ren | mem_mem_wen) & !dmem_ready. All five en=0, no rst.
- Debug hold: debug_en & !(debug_step & !step_prev). All en=0. step_prev is registered each clk.
- Priority (highest first): rst > debug hold > memwait > load-use stall > branch flush. Only the winning action drives outputs; lower-priority actions are suppressed.
- Flush FSM, states IDLE and FLUSH, with counter cnt of width clog2(BRANCH_DELAY+1):
  - IDLE: id_is_branch and no higher-priority action → id_rst=1 this cycle. If BRANCH_DELAY>1, go to FLUSH with cnt=BRANCH_DELAY-1.
  - FLUSH: id_rst=1. cnt decrements when the pipeline advances; go to IDLE when cnt reaches 1 and advances.
  - Debug hold or memwait freezes cnt, and id_rst is not asserted in frozen cycles.
  - A branch stalled by load-use does not start the flush until the stall clears.
- Counters: +1 per cycle in which their action wins; they saturate at all-ones and never wrap.
- Reset mid-flush or mid-stall: FSM returns to IDLE immediately; counters clear.

Decomposition:
- Shared package mips_hazard_pkg: fwd_sel codes (FWD_REG, FWD_ALU_MEM, FWD_LMD_MEM, FWD_WB) and FSM state encodings.
- Sub-module fwd_select: one forwarding comparator per port, instantiated NUM_SRC times by generate.
- FSM, step detector, stall logic and counters stay in the top module.

Test Plan:
1. add $1 in MEM, sub reading $1 in EXE, add $1 also in WB → fwd_sel port0 = 1 (MEM beats WB). Same with dest $0 → fwd_sel = 0.
2. Mode 0: lw $2 in EXE, ID uses $2 → exactly 1 cycle with if_en=id_en=0, exe_rst=1, then fwd_sel=2. Mode 1: 2 stall cycles, then fwd_sel=3. stall_count = 1 and 2 respectively.
3. beq in ID, BRANCH_DELAY=3 → id_rst high 3 consecutive cycles, flush_count=3. Inject dmem_ready=0 for 2 cycles mid-flush → id_rst totals still 3, memwait_count=2.
4. jr $3 in ID while lw $3 is in EXE → stall first, flush starts the cycle after the stall clears.
5. debug_en=1, toggle debug_step 0→1 twice → each stage enable high for exactly 2 single cycles.
6. Assert rst during FLUSH with cnt=2 → outputs go to reset values without a clock edge; after release, no residual id_rst.
